// File: rtl/psum_out_collector.sv
// Per-column circular buffer with wrap-bit pointers; head word is visible combinationally.
// Latency: a pushed word becomes visible at the head on the next cycle.
// Backpressure: a push to a full buffer is dropped; a pop of an empty buffer is ignored.
module psum_col_fifo #(
    parameter int width = 16,
    parameter int depth = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int aw = $clog2(depth);

    logic [aw:0]      wptr;
    logic [aw:0]      rptr;
    logic [width-1:0] mem [depth];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; a zeroed pointer pair makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[aw-1:0]] <= din;
    end
endmodule

// Collects staggered per-column partial sums and pops them as aligned rows.
// Latency: out/o_vld register one cycle after an accepted pop.
// Backpressure: o_ready drops while any column is full; pops are accepted only when every column holds data.
module psum_out_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_vld,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_err
);
    logic [col-1:0]         col_empty;
    logic [col-1:0]         col_full;
    logic [col*psum_bw-1:0] head_row;
    logic                   rd_acc;
    logic                   overflow;
    logic                   underflow;

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_col_fifo #(
            .width (psum_bw),
            .depth (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (wr[c]),
            .pop   (rd_acc),
            .din   (in[c*psum_bw +: psum_bw]),
            .head  (head_row[c*psum_bw +: psum_bw]),
            .empty (col_empty[c]),
            .full  (col_full[c])
        );
    end

    assign o_valid   = ~|col_empty;
    assign o_full    = |col_full;
    assign o_ready   = ~o_full;
    assign rd_acc    = rd && o_valid;
    assign overflow  = |(wr & col_full);
    assign underflow = rd && !o_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out   <= '0;
            o_vld <= 1'b0;
            o_err <= 1'b0;
        end else begin
            o_vld <= rd_acc;
            if (rd_acc) out <= head_row;
            if (overflow || underflow) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_out_collector.sv
module tb_psum_out_collector;
    localparam int COL   = 8;
    localparam int PW    = 16;
    localparam int DEPTH = 64;

    logic               clk;
    logic               reset;
    logic [COL*PW-1:0]  in;
    logic [COL-1:0]     wr;
    logic               rd;
    logic [COL*PW-1:0]  out;
    logic               o_vld, o_valid, o_full, o_ready, o_err;

    int vectors    = 0;
    int miscompares = 0;

    psum_out_collector #(.col(COL), .psum_bw(PW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_vld   (o_vld),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per column plus the registered outputs.
    logic [PW-1:0]     mq [COL][$];
    logic [COL*PW-1:0] exp_out = '0;
    logic              exp_vld = 1'b0;
    logic              exp_err = 1'b0;

    function automatic logic m_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            exp_out = '0;
            exp_vld = 1'b0;
            exp_err = 1'b0;
        end else begin
            logic valid_pre;
            logic [COL-1:0] full_pre;
            valid_pre = m_valid();
            for (int c = 0; c < COL; c++) full_pre[c] = (mq[c].size() == DEPTH);
            exp_vld = rd && valid_pre;
            if (rd && valid_pre)
                for (int c = 0; c < COL; c++) exp_out[c*PW +: PW] = mq[c].pop_front();
            if (rd && !valid_pre) exp_err = 1'b1;
            for (int c = 0; c < COL; c++) begin
                if (wr[c]) begin
                    if (full_pre[c]) exp_err = 1'b1;
                    else mq[c].push_back(in[c*PW +: PW]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [COL*PW-1:0] act, input logic [COL*PW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_valid", {127'b0, o_valid}, {127'b0, m_valid()});
        chk("m_full",  {127'b0, o_full},  {127'b0, m_full()});
        chk("m_ready", {127'b0, o_ready}, {127'b0, !m_full()});
        chk("m_err",   {127'b0, o_err},   {127'b0, exp_err});
        chk("m_vld",   {127'b0, o_vld},   {127'b0, exp_vld});
        chk("m_out",   out, exp_out);
    end

    task automatic step(input logic r, input logic [COL-1:0] w, input logic [COL*PW-1:0] d, input logic rr);
        reset = r;
        wr    = w;
        in    = d;
        rd    = rr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COL*PW-1:0] row(input logic [PW-1:0] v);
        return {COL{v}};
    endfunction

    function automatic logic [COL*PW-1:0] bit1(input logic b);
        return {127'b0, b};
    endfunction

    initial begin
        logic [COL*PW-1:0] d;
        reset = 1'b1; wr = '0; in = '0; rd = 1'b0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_valid", bit1(o_valid), bit1(0));
        chk("rst_full",  bit1(o_full),  bit1(0));
        chk("rst_ready", bit1(o_ready), bit1(1));
        chk("rst_err",   bit1(o_err),   bit1(0));
        chk("rst_vld",   bit1(o_vld),   bit1(0));
        chk("rst_out",   out, '0);

        // Staggered fill
        for (int c = 0; c < COL; c++) begin
            d = '0;
            d[c*PW +: PW] = 16'h0100 + 16'(c);
            step(0, 8'(1 << c), d, 0);
            chk("stag_valid", bit1(o_valid), bit1(c == COL - 1));
        end
        step(0, 0, 0, 1);
        chk("stag_vld", bit1(o_vld), bit1(1));
        chk("stag_out", out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                              16'h0103, 16'h0102, 16'h0101, 16'h0100});
        chk("stag_valid_after", bit1(o_valid), bit1(0));

        // Underflow
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("uf_vld", bit1(o_vld), bit1(0));
        chk("uf_out", out, '0);
        chk("uf_err", bit1(o_err), bit1(1));
        chk("uf_valid", bit1(o_valid), bit1(0));
        step(0, 8'hFF, row(16'h1234), 0);
        step(0, 0, 0, 1);
        chk("uf_pop_out", out, row(16'h1234));

        // Full / overflow
        step(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h01, row(16'(i)), 0);
        chk("ov_full",  bit1(o_full),  bit1(1));
        chk("ov_ready", bit1(o_ready), bit1(0));
        chk("ov_err0",  bit1(o_err),   bit1(0));
        step(0, 8'h01, row(16'hDEAD), 0);
        chk("ov_err1",  bit1(o_err),   bit1(1));
        for (int i = 0; i < DEPTH; i++) step(0, 8'hFE, row(16'h1000 + 16'(i)), 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 1);
            chk("ov_pop_c0", {112'b0, out[PW-1:0]}, {112'b0, 16'(i)});
            chk("ov_pop_c7", {112'b0, out[7*PW +: PW]}, {112'b0, 16'h1000 + 16'(i)});
        end
        chk("ov_empty", bit1(o_valid), bit1(0));

        // Simultaneous read and write
        step(1, 0, 0, 0);
        step(0, 8'hFF, row(16'h5555), 0);
        step(0, 8'hFF, row(16'hAAAA), 1);
        chk("sim_out",   out, row(16'h5555));
        chk("sim_valid", bit1(o_valid), bit1(1));
        step(0, 0, 0, 1);
        chk("sim_out2",  out, row(16'hAAAA));
        chk("sim_err",   bit1(o_err), bit1(0));

        // Wrap-around: write-all / pop pairs across 3*depth rows
        step(1, 0, 0, 0);
        for (int k = 0; k < 3 * DEPTH; k++) begin
            for (int c = 0; c < COL; c++) d[c*PW +: PW] = 16'(k * COL + c);
            step(0, 8'hFF, d, 0);
            step(0, 0, 0, 1);
            chk("wrap_out", out, d);
        end

        // Reset mid-operation
        step(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 8'hFF, row(16'h0C00 + 16'(k)), 0);
        step(1, 0, 0, 1);
        chk("mid_vld",   bit1(o_vld),   bit1(0));
        chk("mid_valid", bit1(o_valid), bit1(0));
        chk("mid_ready", bit1(o_ready), bit1(1));
        chk("mid_out",   out, '0);
        chk("mid_err",   bit1(o_err),   bit1(0));

        // Randomized traffic: fill-biased then drain-biased phases
        for (int ph = 0; ph < 2; ph++) begin
            step(1, 0, 0, 0);
            for (int n = 0; n < 1500; n++) begin
                logic r, rr;
                r  = ($urandom_range(0, 299) == 0);
                rr = (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
                d  = {$urandom, $urandom, $urandom, $urandom};
                step(r, 8'($urandom), d, rr);
            end
        end

        step(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
